mem_port_arbiter: RTL and testbench

//  Shares one single-port unified memory between the IF stage (instruction fetch)
//  and the MEM stage (loads/stores driven by MemRead/MemWrite/DMType from ctrl).

---
 rtl/mem_port_arbiter_if.sv | 48 ++++
 rtl/mem_port_arbiter.sv | 157 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 335 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Pipeline-side (IF and MEM stage) and memory-side signals of the unified memory arbiter.
// The arbiter uses the slave view; the pipeline and memory model drive through the master view.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_flush;
    logic              if_ack;
    logic [DATA_W-1:0] if_rdata;
    logic              if_stall;

    logic              dm_req;
    logic              dm_we;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic [2:0]        dm_type;
    logic              dm_ack;
    logic [DATA_W-1:0] dm_rdata;
    logic              dm_stall;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [2:0]        mem_type;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;

    modport master (
        output if_req, if_addr, if_flush,
        input  if_ack, if_rdata, if_stall,
        output dm_req, dm_we, dm_addr, dm_wdata, dm_type,
        input  dm_ack, dm_rdata, dm_stall,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_type,
        output mem_rdata, mem_ready
    );

    modport slave (
        input  if_req, if_addr, if_flush,
        output if_ack, if_rdata, if_stall,
        input  dm_req, dm_we, dm_addr, dm_wdata, dm_type,
        output dm_ack, dm_rdata, dm_stall,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_type,
        input  mem_rdata, mem_ready
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and data access:
// data side wins by default, fetch is forced through after STARVE_LIMIT losses, redirects drop fetches.
module mem_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 3
) (
    input  logic              clk,
    input  logic              rstn,
    mem_port_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_DM = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              drop_q, drop_d;
    logic              if_ack_q, if_ack_d;
    logic              dm_ack_q, dm_ack_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [2:0]        mem_type_q, mem_type_d;

    logic if_valid;
    logic dm_valid;
    logic if_wins;

    // A requester whose ack is showing is still holding the request that was just served.
    assign if_valid = bus.if_req & ~if_ack_q & ~bus.if_flush;
    assign dm_valid = bus.dm_req & ~dm_ack_q;
    assign if_wins  = if_valid & (~dm_valid | (cnt_q == LIMIT));

    // NOTE: every variable driven here gets its default before the case, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        drop_d      = drop_q;
        if_ack_d    = 1'b0;
        dm_ack_d    = 1'b0;
        if_rdata_d  = if_rdata_q;
        dm_rdata_d  = dm_rdata_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_type_d  = mem_type_q;

        unique case (state_q)
            IDLE: begin
                if (if_wins) begin
                    state_d     = BUSY_IF;
                    cnt_d       = '0;
                    drop_d      = 1'b0;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = bus.if_addr;
                    mem_wdata_d = '0;
                    mem_type_d  = 3'b000;
                end else if (dm_valid) begin
                    state_d     = BUSY_DM;
                    mem_req_d   = 1'b1;
                    mem_we_d    = bus.dm_we;
                    mem_addr_d  = bus.dm_addr;
                    mem_wdata_d = bus.dm_wdata;
                    mem_type_d  = bus.dm_type;
                    // Only a contended loss counts; if_wins already caps cnt at LIMIT.
                    if (if_valid) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            BUSY_IF: begin
                if (bus.if_flush) begin
                    drop_d = 1'b1;
                end
                if (bus.mem_ready) begin
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                    drop_d    = 1'b0;
                    if (!(drop_q || bus.if_flush)) begin
                        if_ack_d   = 1'b1;
                        if_rdata_d = bus.mem_rdata;
                    end
                end
            end
            BUSY_DM: begin
                if (bus.mem_ready) begin
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                    dm_ack_d  = 1'b1;
                    if (!mem_we_q) begin
                        dm_rdata_d = bus.mem_rdata;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: the synchronous reset clears every register, including the read-data holders, because they are ordinary flops rather than a memory array.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            drop_q      <= 1'b0;
            if_ack_q    <= 1'b0;
            dm_ack_q    <= 1'b0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_type_q  <= 3'b000;
        end else begin
            // NOTE: non-blocking assignments let every flop sample the old values at the same edge.
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            drop_q      <= drop_d;
            if_ack_q    <= if_ack_d;
            dm_ack_q    <= dm_ack_d;
            if_rdata_q  <= if_rdata_d;
            dm_rdata_q  <= dm_rdata_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_type_q  <= mem_type_d;
        end
    end

    assign bus.if_ack    = if_ack_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.if_stall  = if_valid;
    assign bus.dm_ack    = dm_ack_q;
    assign bus.dm_rdata  = dm_rdata_q;
    assign bus.dm_stall  = dm_valid;
    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_type  = mem_type_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios followed by a randomized run,
// all compared against a transaction-level model of the arbitration rules.
module tb_mem_port_arbiter;
    localparam int ADDR_W       = 32;
    localparam int DATA_W       = 32;
    localparam int STARVE_LIMIT = 4;
    localparam int CNT_W        = 3;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    mem_port_arbiter #(
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .STARVE_LIMIT(STARVE_LIMIT),
        .CNT_W       (CNT_W)
    ) dut (
        .clk (clk),
        .rstn(rstn),
        .bus (bus)
    );

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [2:0]  typ;
        logic [31:0] wdata;
    } grant_t;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Reference model: who owns the memory, the request it is serving, and IF's consecutive losses.
    bit          m_busy     = 0;
    bit          m_is_if    = 0;
    bit          m_drop     = 0;
    int          m_losses   = 0;
    logic [31:0] m_addr     = '0;
    logic [31:0] m_wdata    = '0;
    bit          m_we       = 0;
    logic [2:0]  m_type     = '0;
    bit          m_if_ack   = 0;
    bit          m_dm_ack   = 0;
    logic [31:0] m_if_rdata = '0;
    logic [31:0] m_dm_rdata = '0;

    grant_t      grants[$];
    bit          prev_mem_req  = 0;
    bit          last_if_stall = 0;
    bit          last_dm_stall = 0;

    // Memory responder: mem_wait < 0 picks a random 0..3 wait per access.
    int          mem_wait      = 0;
    bit          mem_pending   = 0;
    int          mem_left      = 0;
    bit          mem_rand_data = 0;
    logic [31:0] mem_fixed     = '0;
    logic [2:0]  dm_types [5]  = '{3'b000, 3'b001, 3'b010, 3'b101, 3'b110};

    task automatic model_reset();
        m_busy = 0; m_is_if = 0; m_drop = 0; m_losses = 0;
        m_addr = '0; m_wdata = '0; m_we = 0; m_type = '0;
        m_if_ack = 0; m_dm_ack = 0; m_if_rdata = '0; m_dm_rdata = '0;
    endtask

    task automatic set_idle();
        bus.if_req = 0; bus.if_addr = '0; bus.if_flush = 0;
        bus.dm_req = 0; bus.dm_we = 0; bus.dm_addr = '0; bus.dm_wdata = '0; bus.dm_type = '0;
        bus.mem_ready = 0; bus.mem_rdata = '0;
    endtask

    task automatic mem_drive();
        if (bus.mem_req !== 1'b1) begin
            mem_pending   = 0;
            bus.mem_ready = 0;
        end else begin
            if (!mem_pending) begin
                mem_pending = 1;
                mem_left    = (mem_wait < 0) ? int'($urandom_range(0, 3)) : mem_wait;
            end
            bus.mem_ready = (mem_left == 0);
            if (mem_left == 0) mem_pending = 0;
            else mem_left--;
        end
        bus.mem_rdata = mem_rand_data ? $urandom : mem_fixed;
    endtask

    // Inputs for the current cycle are already driven; check stalls, advance the model over
    // the coming edge, then compare registered outputs at the next falling edge.
    task automatic tick();
        bit ifv;
        bit dmv;
        #1;
        last_if_stall = bus.if_stall;
        last_dm_stall = bus.dm_stall;
        check("if_stall", bus.if_stall, bus.if_req & ~m_if_ack & ~bus.if_flush);
        check("dm_stall", bus.dm_stall, bus.dm_req & ~m_dm_ack);
        if (!rstn) begin
            model_reset();
        end else if (!m_busy) begin
            ifv = bus.if_req && !m_if_ack && !bus.if_flush;
            dmv = bus.dm_req && !m_dm_ack;
            m_if_ack = 0;
            m_dm_ack = 0;
            if (ifv && (!dmv || m_losses == STARVE_LIMIT)) begin
                m_busy = 1; m_is_if = 1; m_drop = 0; m_losses = 0;
                m_addr = bus.if_addr; m_we = 0; m_type = 3'b000;
            end else if (dmv) begin
                m_busy = 1; m_is_if = 0;
                if (ifv) m_losses++;
                m_addr = bus.dm_addr; m_we = bus.dm_we; m_wdata = bus.dm_wdata; m_type = bus.dm_type;
            end
        end else begin
            m_if_ack = 0;
            m_dm_ack = 0;
            if (m_is_if && bus.if_flush) m_drop = 1;
            if (bus.mem_ready) begin
                m_busy = 0;
                if (m_is_if) begin
                    if (!m_drop) begin
                        m_if_ack   = 1;
                        m_if_rdata = bus.mem_rdata;
                    end
                end else begin
                    m_dm_ack = 1;
                    if (!m_we) m_dm_rdata = bus.mem_rdata;
                end
                m_drop = 0;
            end
        end
        @(negedge clk);
        check("mem_req", bus.mem_req, m_busy);
        if (m_busy) begin
            check("mem_addr", bus.mem_addr, m_addr);
            check("mem_we", bus.mem_we, m_we);
            check("mem_type", bus.mem_type, m_type);
            if (m_we) check("mem_wdata", bus.mem_wdata, m_wdata);
        end
        check("if_ack", bus.if_ack, m_if_ack);
        check("dm_ack", bus.dm_ack, m_dm_ack);
        check("if_rdata", bus.if_rdata, m_if_rdata);
        check("dm_rdata", bus.dm_rdata, m_dm_rdata);
        if (bus.mem_req === 1'b1 && !prev_mem_req) begin
            grant_t g;
            g.addr = bus.mem_addr; g.we = bus.mem_we; g.typ = bus.mem_type; g.wdata = bus.mem_wdata;
            grants.push_back(g);
        end
        prev_mem_req = (bus.mem_req === 1'b1);
    endtask

    // lat counts cycles from the request cycle up to and including the ack cycle.
    task automatic wait_ack(input string tag, input bit on_if, output int lat, output int stalls);
        lat    = 1;
        stalls = 0;
        for (int i = 0; i < 30; i++) begin
            mem_drive();
            tick();
            lat++;
            stalls += on_if ? int'(last_if_stall) : int'(last_dm_stall);
            if (on_if ? bus.if_ack : bus.dm_ack) return;
        end
        check({tag, "_ack_timeout"}, on_if ? bus.if_ack : bus.dm_ack, 1);
    endtask

    task automatic drive_random();
        bus.if_flush = 0;
        if (bus.if_ack || !bus.if_req) begin
            bus.if_req  = ($urandom_range(0, 2) != 0);
            bus.if_addr = 32'($urandom_range(0, 255)) << 2;
        end else if ($urandom_range(0, 9) == 0) begin
            bus.if_flush = 1;
            bus.if_addr  = 32'($urandom_range(0, 255)) << 2;
        end
        if (bus.dm_ack || !bus.dm_req) begin
            bus.dm_req   = ($urandom_range(0, 2) != 0);
            bus.dm_we    = 1'($urandom_range(0, 1));
            bus.dm_addr  = $urandom;
            bus.dm_wdata = $urandom;
            bus.dm_type  = dm_types[$urandom_range(0, 4)];
        end
        mem_drive();
    endtask

    initial begin
        int lat;
        int st;
        int k;
        int n_req;
        int n_ack;
        logic [31:0] exp_addr;

        set_idle();
        rstn = 0;
        repeat (2) begin
            mem_drive();
            tick();
        end
        check("rst_mem_req", bus.mem_req, 0);
        check("rst_mem_addr", bus.mem_addr, 0);
        check("rst_if_rdata", bus.if_rdata, 0);
        check("rst_cnt", dut.cnt_q, 0);
        rstn = 1;

        // Fetch only, memory ready in the first request cycle.
        grants.delete();
        mem_wait = 0; mem_fixed = 32'h0050_0093;
        bus.if_req = 1; bus.if_addr = 32'h0000_0040;
        wait_ack("t1", 1, lat, st);
        check("t1_latency", lat, 3);
        check("t1_if_rdata", bus.if_rdata, 32'h0050_0093);
        check("t1_grants", grants.size(), 1);
        if (grants.size() > 0) begin
            check("t1_mem_addr", grants[0].addr, 32'h40);
            check("t1_mem_type", grants[0].typ, 3'b000);
            check("t1_mem_we", grants[0].we, 0);
        end
        set_idle(); mem_drive(); tick();

        // Contention: the store goes first, then the fetch.
        grants.delete();
        mem_fixed = 32'h1234_5678;
        bus.if_req = 1; bus.if_addr = 32'h80;
        bus.dm_req = 1; bus.dm_we = 1; bus.dm_addr = 32'h100; bus.dm_wdata = 32'hDEAD_BEEF; bus.dm_type = 3'b000;
        wait_ack("t2_dm", 0, lat, st);
        check("t2_store_keeps_dm_rdata", bus.dm_rdata, 0);
        bus.dm_req = 0; bus.dm_we = 0;
        wait_ack("t2_if", 1, lat, st);
        set_idle(); mem_drive(); tick();
        check("t2_grants", grants.size(), 2);
        if (grants.size() == 2) begin
            check("t2_first_addr", grants[0].addr, 32'h100);
            check("t2_first_we", grants[0].we, 1);
            check("t2_first_type", grants[0].typ, 3'b000);
            check("t2_first_wdata", grants[0].wdata, 32'hDEAD_BEEF);
            check("t2_second_addr", grants[1].addr, 32'h80);
            check("t2_second_we", grants[1].we, 0);
        end
        check("t2_cnt", dut.cnt_q, 0);

        // Starvation: IF steps aside only during DM ack cycles, so every IDLE grant is contended.
        grants.delete();
        mem_fixed = 32'h0000_1111;
        k = 0;
        bus.if_addr = 32'h40; bus.dm_we = 0; bus.dm_type = 3'b000;
        for (int i = 0; i < 100 && grants.size() < 6; i++) begin
            if (bus.dm_ack) k++;
            bus.dm_req  = 1;
            bus.dm_addr = 32'h200 + 32'(4 * k);
            bus.if_req  = !bus.dm_ack;
            mem_drive();
            tick();
        end
        set_idle();
        repeat (4) begin mem_drive(); tick(); end
        check("t3_grants", grants.size(), 6);
        for (int j = 0; j < grants.size() && j < 6; j++) begin
            exp_addr = (j < 4) ? 32'h200 + 32'(4 * j) : (j == 4) ? 32'h40 : 32'h210;
            check($sformatf("t3_grant%0d_addr", j), grants[j].addr, exp_addr);
        end

        // Flush during a fetch with a three-cycle memory access.
        grants.delete();
        mem_wait = 2; mem_fixed = 32'hBAD0_BAD0;
        bus.if_req = 1; bus.if_addr = 32'h300;
        mem_drive(); tick();
        n_req = 0; n_ack = 0;
        for (int i = 0; i < 8; i++) begin
            bus.if_flush = (i == 0);
            if (i > 0) bus.if_req = 0;
            n_req += int'(bus.mem_req);
            n_ack += int'(bus.if_ack);
            mem_drive();
            tick();
        end
        n_ack += int'(bus.if_ack);
        check("t4_mem_req_cycles", n_req, 3);
        check("t4_if_ack_count", n_ack, 0);
        check("t4_if_rdata", bus.if_rdata, 32'h0000_1111);
        check("t4_idle", bus.mem_req, 0);

        // lbu with two memory wait cycles.
        grants.delete();
        mem_wait = 2; mem_fixed = 32'h0000_00A5;
        bus.dm_req = 1; bus.dm_we = 0; bus.dm_type = 3'b101; bus.dm_addr = 32'h203;
        wait_ack("t5", 0, lat, st);
        check("t5_stall_cycles", st, 4);
        check("t5_latency", lat, 5);
        check("t5_dm_rdata", bus.dm_rdata, 32'hA5);
        if (grants.size() > 0) begin
            check("t5_mem_type", grants[0].typ, 3'b101);
            check("t5_mem_addr", grants[0].addr, 32'h203);
        end
        set_idle(); mem_drive(); tick();

        // Reset while the data access is in flight, then re-issue it.
        mem_wait = 3; mem_fixed = 32'h0000_0077;
        bus.dm_req = 1; bus.dm_we = 0; bus.dm_type = 3'b000; bus.dm_addr = 32'h400;
        mem_drive(); tick();
        mem_drive(); tick();
        rstn = 0;
        mem_drive(); tick();
        check("t6_mem_req", bus.mem_req, 0);
        check("t6_dm_ack", bus.dm_ack, 0);
        check("t6_if_ack", bus.if_ack, 0);
        rstn = 1; mem_wait = 0;
        wait_ack("t6", 0, lat, st);
        check("t6_latency", lat, 3);
        check("t6_dm_rdata", bus.dm_rdata, 32'h77);
        set_idle(); mem_drive(); tick();

        // Randomized traffic against the model.
        mem_wait = -1; mem_rand_data = 1;
        for (int i = 0; i < 4000; i++) begin
            drive_random();
            tick();
        end
        set_idle();
        repeat (8) begin mem_drive(); tick(); end
        check("final_idle", bus.mem_req, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
